// File: rtl/rescale_row_scheduler.sv
// Plans line-buffer refills per output row, then scans columns to the bilinear interpolator.
// Optional LOAD watchdog enabled by defining RESCALE_SCHED_TIMEOUT_EN.
module rescale_row_scheduler #(
  parameter int unsigned IN_W    = 320,
  parameter int unsigned IN_H    = 240,
  parameter int unsigned FRAC    = 8,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            start,
  input  logic [9:0]      cfg_out_w,
  input  logic [8:0]      cfg_out_h,
  input  logic [15:0]     cfg_x_step,
  input  logic [15:0]     cfg_y_step,
  output logic            skip,
  output logic [8:0]      row_to_wait,
  output logic            in_stream_ready,
  input  logic            buffer_done,
  output logic [10:0]     neighbor_offset,
  output logic [FRAC-1:0] frac_x,
  output logic [FRAC-1:0] frac_y,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic            row_last,
  output logic            busy,
  output logic            frame_done,
  output logic            timeout_err
);
  localparam int unsigned PW = 26;

  typedef enum logic [2:0] {S_IDLE, S_PLAN, S_LOAD, S_SCAN, S_ROW_END} state_t;

  state_t        state_q, state_d;
  logic [9:0]    out_w_q, out_w_d;
  logic [8:0]    out_h_q, out_h_d;
  logic [15:0]   x_step_q, x_step_d;
  logic [15:0]   y_step_q, y_step_d;
  logic [8:0]    oy_q, oy_d;
  logic [9:0]    ox_q, ox_d;
  logic [PW-1:0] ypos_q, ypos_d;
  logic [PW-1:0] xpos_q, xpos_d;
  logic [9:0]    nsr_q, nsr_d;
  logic [8:0]    top_row_q, top_row_d;
  logic          top_inv_q, top_inv_d;
  logic          skip_q, skip_d;
  logic [8:0]    wait_q, wait_d;
  logic          done_q, done_d;
  logic          err_set;
  logic          load_timeout;

  // Source row/column with clamping so the 2x2 neighbourhood never leaves the image.
  logic [PW-1:0]   r_raw, c_raw;
  logic            clamp_y, clamp_x;
  logic [8:0]      r;
  logic [9:0]      r_ext, top_ext;
  logic [10:0]     c;
  logic [FRAC-1:0] fy, fx;
  logic            last_col;

  assign r_raw    = ypos_q >> FRAC;
  assign c_raw    = xpos_q >> FRAC;
  assign clamp_y  = (r_raw >= PW'(IN_H - 1));
  assign clamp_x  = (c_raw >= PW'(IN_W - 1));
  assign r        = clamp_y ? 9'(IN_H - 2) : r_raw[8:0];
  assign fy       = clamp_y ? '1 : ypos_q[FRAC-1:0];
  assign c        = clamp_x ? 11'(IN_W - 2) : c_raw[10:0];
  assign fx       = clamp_x ? '1 : xpos_q[FRAC-1:0];
  assign r_ext    = {1'b0, r};
  assign top_ext  = {1'b0, top_row_q};
  assign last_col = (ox_q == out_w_q - 10'd1);

  always_comb begin
    state_d   = state_q;
    out_w_d   = out_w_q;
    out_h_d   = out_h_q;
    x_step_d  = x_step_q;
    y_step_d  = y_step_q;
    oy_d      = oy_q;
    ox_d      = ox_q;
    ypos_d    = ypos_q;
    xpos_d    = xpos_q;
    nsr_d     = nsr_q;
    top_row_d = top_row_q;
    top_inv_d = top_inv_q;
    skip_d    = skip_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_PLAN;
          out_w_d   = cfg_out_w;
          out_h_d   = cfg_out_h;
          x_step_d  = cfg_x_step;
          y_step_d  = cfg_y_step;
          oy_d      = '0;
          ox_d      = '0;
          ypos_d    = '0;
          xpos_d    = '0;
          nsr_d     = '0;
          top_inv_d = 1'b1;
        end
      end
      S_PLAN: begin
        if (!top_inv_q && (r == top_row_q)) begin
          state_d = S_SCAN;
        end else if (!top_inv_q && (r_ext == top_ext + 10'd1) && (nsr_q == r_ext + 10'd1)) begin
          skip_d  = 1'b0;
          wait_d  = '0;
          state_d = S_LOAD;
        end else begin
          skip_d  = 1'b1;
          wait_d  = 9'(r_ext - nsr_q);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (buffer_done) begin
          top_row_d = r;
          top_inv_d = 1'b0;
          nsr_d     = r_ext + 10'd2;
          state_d   = S_SCAN;
        end else if (load_timeout) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (pix_ready) begin
          ox_d   = ox_q + 10'd1;
          xpos_d = xpos_q + PW'(x_step_q);
          if (last_col) state_d = S_ROW_END;
        end
      end
      S_ROW_END: begin
        ox_d   = '0;
        xpos_d = '0;
        oy_d   = oy_q + 9'd1;
        ypos_d = ypos_q + PW'(y_step_q);
        if (oy_q == out_h_q - 9'd1) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_PLAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      out_w_q   <= '0;
      out_h_q   <= '0;
      x_step_q  <= '0;
      y_step_q  <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      ypos_q    <= '0;
      xpos_q    <= '0;
      nsr_q     <= '0;
      top_row_q <= '0;
      top_inv_q <= 1'b1;
      skip_q    <= 1'b0;
      wait_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_w_q   <= out_w_d;
      out_h_q   <= out_h_d;
      x_step_q  <= x_step_d;
      y_step_q  <= y_step_d;
      oy_q      <= oy_d;
      ox_q      <= ox_d;
      ypos_q    <= ypos_d;
      xpos_q    <= xpos_d;
      nsr_q     <= nsr_d;
      top_row_q <= top_row_d;
      top_inv_q <= top_inv_d;
      skip_q    <= skip_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
    end
  end

`ifdef RESCALE_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tmo_cnt_q;
  logic          tmo_err_q;

  assign load_timeout = (tmo_cnt_q == CW'(TIMEOUT - 1));

  // Counter restarts on every entry to LOAD; the error is cleared by the next accepted start.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == S_LOAD) ? tmo_cnt_q + CW'(1) : '0;
      if (err_set)
        tmo_err_q <= 1'b1;
      else if ((state_q == S_IDLE) && start)
        tmo_err_q <= 1'b0;
    end
  end

  assign timeout_err = tmo_err_q;
`else
  logic unused_tmo;
  assign load_timeout = 1'b0;
  assign timeout_err  = 1'b0;
  assign unused_tmo   = err_set | (TIMEOUT == 0);
`endif

  assign skip            = skip_q;
  assign row_to_wait     = wait_q;
  assign in_stream_ready = (state_q == S_LOAD);
  assign pix_valid       = (state_q == S_SCAN);
  assign neighbor_offset = pix_valid ? c : '0;
  assign frac_x          = pix_valid ? fx : '0;
  assign frac_y          = pix_valid ? fy : '0;
  assign row_last        = pix_valid & last_col;
  assign busy            = (state_q != S_IDLE);
  assign frame_done      = done_q;

endmodule

// File: doc/rescale_row_scheduler.md
Name: rescale_row_scheduler

Overview:
- Sequencing controller for the two-row input line buffer (`buffer_in`) of the rescale IP.
- For each output row, computes the source row position and decides how the buffer is refilled:
  - reuse: no load;
  - single-row refill: `skip=0`;
  - two-row refill: `skip=1`, with `row_to_wait` rows discarded first.
- Then scans output columns, driving `neighbor_offset` and fractional weights to the downstream bilinear interpolator with a valid/ready handshake.

Parameters:
- IN_W, 320, input row width in pixels (matches buffer row size).
- IN_H, 240, input rows per frame.
- FRAC, 8, fractional bits of the fixed-point step and position values.
- TIMEOUT, 2000000, cycles allowed from `in_stream_ready` assertion to `buffer_done` (used only with the optional feature).

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin frame
- cfg_out_w  in  10  output columns (1..IN_W)
- cfg_out_h  in  9  output rows (1..IN_H)
- cfg_x_step  in  16  source step per output column, unsigned 8.8
- cfg_y_step  in  16  source step per output row, unsigned 8.8
- skip  out  1  to `buffer_in`: 1 = load two fresh rows, 0 = load one row
- row_to_wait  out  9  to `buffer_in`: rows to discard before loading
- in_stream_ready  out  1  to `buffer_in`: load request, held until `buffer_done`
- buffer_done  in  1  one-cycle pulse from `buffer_in`
- neighbor_offset  out  11  source column c of the top-left neighbour
- frac_x  out  8  horizontal weight
- frac_y  out  8  vertical weight
- pix_valid  out  1  neighbour address and weights valid
- pix_ready  in  1  interpolator accepts
- row_last  out  1  with `pix_valid`: last column of the output row
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- timeout_err  out  1  sticky error (optional feature; tied 0 otherwise)

Behaviour:
- Reset (async, `resetn=0`): state IDLE; all outputs 0, including `row_to_wait` and `neighbor_offset`; internal `oy`, `ox`, `ypos`, `xpos`, `next_stream_row` and `top_row` cleared. `top_row` invalid flag set. Reset mid-frame aborts immediately; no `frame_done`.
- Config inputs are sampled on `start` in IDLE. `start` is ignored while `busy=1`.
- Position arithmetic:
  - `ypos = oy*cfg_y_step` (17+ bit accumulator, added per row).
  - `r = ypos>>FRAC`, `frac_y = ypos[FRAC-1:0]`.
  - If `r >= IN_H-1`: `r = IN_H-2`, `frac_y = 8'hFF`.
  - Columns use the same rules: `c = xpos>>FRAC`; if `c >= IN_W-1`, `c = IN_W-2` and `frac_x = 8'hFF`.
- States:
  - IDLE -> PLAN on `start`. Sets `busy`; `next_stream_row=0`; `top_row` invalid.
  - PLAN (1 cycle), three cases:
    - `top_row` valid and `r == top_row`: reuse, go to SCAN.
    - `top_row` valid and `r == top_row+1` and `next_stream_row == r+1`: `skip=0`, `row_to_wait=0`, go to LOAD.
    - Otherwise: `skip=1`, `row_to_wait = r - next_stream_row`, go to LOAD.
  - A required row already passed (`r+1 < next_stream_row` with no reuse) cannot happen with monotonic steps; for `cfg_y_step=0` the controller always reuses.
  - LOAD: `in_stream_ready=1`, with `skip` and `row_to_wait` held stable. On `buffer_done`:
    - drop `in_stream_ready` the same edge;
    - set `top_row = r` and `next_stream_row = r+2`;
    - go to SCAN.
  - SCAN:
    - `pix_valid=1`; `neighbor_offset = c` zero-extended; `row_last = (ox == cfg_out_w-1)`.
    - Outputs hold while `pix_valid & !pix_ready`.
    - On accept: `ox++`, `xpos += cfg_x_step`.
    - On accept with `row_last`: go to ROW_END.
  - ROW_END:
    - `ox=0`, `xpos=0`, `oy++`, `ypos += cfg_y_step`.
    - If `oy` was `cfg_out_h-1`: go to IDLE, pulse `frame_done`, clear `busy`.
    - Otherwise go to PLAN.
- Throughput: one pixel per cycle in SCAN under continuous `pix_ready`. Row overhead is 2 cycles (ROW_END, PLAN) plus load time.
- Input rows beyond the last required row are not drained; the upstream TLAST/frame logic owns the frame tail.

Optional Feature:
- Macro: `RESCALE_SCHED_TIMEOUT_EN`.
- Defined:
  - Counter runs while in LOAD.
  - Reaching TIMEOUT sets sticky `timeout_err`, drops `in_stream_ready`, clears `busy`, and returns to IDLE without `frame_done`.
  - `timeout_err` is cleared only by `resetn` or the next accepted `start`.
- Undefined: no counter; `timeout_err` tied 0; LOAD waits indefinitely.

Test Plan:
- 2x downscale (`x_step=y_step=0x0200`, out 160x120, `pix_ready=1`) -> every row: `skip=1`.
  - Row 0: `row_to_wait=0`.
  - Row 1 (r=2): `row_to_wait=0`.
  - Offsets 0,2,4..318.
  - `frame_done` after 19200 accepts.
- 1x (`step=0x0100`, out 320x240) -> row 0: `skip=1`, wait 0; rows 1..238: `skip=0`; row 239: clamped r=238, `frac_y=FF`, reuse (no LOAD); col 319: offset 318, `frac_x=FF`.
- 2x upscale (`step=0x0080`) -> row 1: `r=0`, `frac_y=0x80`, reuse (`in_stream_ready` stays 0); row 2: `skip=0` load.
- 3x downscale (`step=0x0300`) -> row 1: `r=3`, `next_stream_row=2`, `skip=1`, `row_to_wait=1`.
- Backpressure: `pix_ready` low 5 cycles mid-row -> `neighbor_offset`, `frac_x` and `row_last` stable; no column skipped. Pulse `start` while busy -> ignored.
- Assert `resetn` low during LOAD -> all outputs 0 asynchronously. With `RESCALE_SCHED_TIMEOUT_EN` and TIMEOUT=100, withhold `buffer_done` -> `timeout_err=1` at cycle 100 of LOAD, `busy=0`.
